// File: rtl/project3_test_bench_by_instructor.sv
// 4-entry register file plus ALU, executing one 16-bit instruction per valid clock.
// Latency: registers, result, flags and done update on the edge that samples instr.
// No backpressure: one instruction is accepted every cycle that instr_valid is high.
module project3_test_bench_by_instructor #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    input  logic [1:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             done
);

    logic [WIDTH-1:0] regs [NREGS];

    logic [3:0]       opcode;
    logic [1:0]       rd;
    logic [1:0]       rs;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             wr_en;
    logic [WIDTH:0]   wide;

    assign opcode   = instr[15:12];
    assign rd       = instr[11:10];
    assign rs       = instr[9:8];
    assign imm      = WIDTH'(instr[7:0]);
    assign a        = regs[rd];
    assign b        = regs[rs];
    assign dbg_data = regs[dbg_sel];

    // Opcodes 0 and 12-15 leave registers and flags untouched.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wr_en   = 1'b1;
        wide    = '0;
        case (opcode)
            4'd1:  alu_res = imm;
            4'd2:  alu_res = b;
            4'd3: begin
                wide    = {1'b0, a} + {1'b0, b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            // The extra top bit of an unsigned difference is the borrow.
            4'd4: begin
                wide    = {1'b0, a} - {1'b0, b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            4'd5:  alu_res = a & b;
            4'd6:  alu_res = a | b;
            4'd7:  alu_res = a ^ b;
            4'd8:  alu_res = ~b;
            4'd9: begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_c   = a[WIDTH-1];
            end
            4'd10: begin
                alu_res = {1'b0, a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            4'd11: begin
                wide    = {1'b0, a} + {1'b0, imm};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            result <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= instr_valid;
            if (instr_valid && wr_en) begin
                regs[rd] <= alu_res;
                result   <= alu_res;
                flag_z   <= (alu_res == '0);
                flag_c   <= alu_c;
                flag_n   <= alu_res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_project3_test_bench_by_instructor.sv
// Randomized and directed bench for the register-file/ALU core against an arithmetic model.
module tb_project3_test_bench_by_instructor;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic [7:0]  result;
    logic        flag_z;
    logic        flag_c;
    logic        flag_n;
    logic        done;

    project3_test_bench_by_instructor #(.WIDTH(8), .NREGS(4)) dut (
        .clk(clk),
        .reset(reset),
        .instr_valid(instr_valid),
        .instr(instr),
        .dbg_sel(dbg_sel),
        .dbg_data(dbg_data),
        .result(result),
        .flag_z(flag_z),
        .flag_c(flag_c),
        .flag_n(flag_n),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    int m_regs [4];
    int m_result;
    int m_z, m_c, m_n, m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ins(input int op, input int d, input int s, input int im);
        logic [15:0] w;
        w = {op[3:0], d[1:0], s[1:0], im[7:0]};
        return w;
    endfunction

    // Reference behaviour computed with plain integer arithmetic.
    task automatic model(input bit rst, input bit v, input logic [15:0] i);
        int op, d, s, a, b, im, r, c;
        bit wr;
        if (rst) begin
            for (int k = 0; k < 4; k++) m_regs[k] = 0;
            m_result = 0; m_z = 0; m_c = 0; m_n = 0; m_done = 0;
            return;
        end
        m_done = v;
        if (!v) return;
        op = i[15:12]; d = i[11:10]; s = i[9:8]; im = i[7:0];
        a = m_regs[d]; b = m_regs[s];
        r = 0; c = 0; wr = 1;
        case (op)
            1:  r = im;
            2:  r = b;
            3:  begin r = a + b;  c = (r > 255); end
            4:  begin r = a - b;  c = (a < b);   end
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = 255 - b;
            9:  begin r = a * 2;  c = (a >= 128); end
            10: begin r = a / 2;  c = a % 2;      end
            11: begin r = a + im; c = (r > 255);  end
            default: wr = 0;
        endcase
        if (wr) begin
            r = r & 255;
            m_regs[d] = r;
            m_result  = r;
            m_z = (r == 0);
            m_n = (r >= 128);
            m_c = c;
        end
    endtask

    // Inputs change 2 time units after a rising edge; the model follows each edge.
    task automatic step(input bit rst, input bit v, input logic [15:0] i);
        reset       = rst;
        instr_valid = v;
        instr       = i;
        dbg_sel     = 2'($urandom_range(0, 3));
        @(posedge clk);
        model(rst, v, i);
        started = 1;
        #2;
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("result", result, m_result);
            chk("flag_z", flag_z, m_z);
            chk("flag_c", flag_c, m_c);
            chk("flag_n", flag_n, m_n);
            chk("done", done, m_done);
            chk("dbg_data", dbg_data, m_regs[dbg_sel]);
        end
    end

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0; dbg_sel = '0;
        #2;

        // Reset wins over a valid LDI.
        step(1, 1, ins(1, 1, 0, 8'h55));
        step(1, 1, ins(1, 1, 0, 8'h55));
        chk("rst_done", done, 0);
        chk("rst_flags", {flag_z, flag_c, flag_n}, 0);
        for (int k = 0; k < 4; k++) begin
            dbg_sel = 2'(k);
            #1;
            chk("rst_dbg", dbg_data, 0);
        end

        step(0, 1, ins(1, 0, 0, 8'h7F));
        step(0, 1, ins(1, 1, 0, 8'h01));
        step(0, 1, ins(3, 0, 1, 8'hAA));
        chk("add_res", result, 8'h80);
        chk("add_model", m_regs[0], 8'h80);
        chk("add_nzc", {flag_n, flag_z, flag_c}, 3'b100);
        step(0, 1, ins(1, 2, 0, 8'hFF));
        step(0, 1, ins(11, 2, 3, 8'h01));
        chk("addi_res", result, 8'h00);
        chk("addi_model", m_regs[2], 0);
        chk("addi_nzc", {flag_n, flag_z, flag_c}, 3'b011);

        step(0, 1, ins(1, 0, 0, 8'h03));
        step(0, 1, ins(1, 1, 0, 8'h05));
        step(0, 1, ins(4, 0, 1, 8'h00));
        chk("sub_res", result, 8'hFE);
        chk("sub_model", m_regs[0], 8'hFE);
        chk("sub_nzc", {flag_n, flag_z, flag_c}, 3'b101);
        step(0, 1, ins(4, 1, 1, 8'h00));
        chk("subself_res", result, 8'h00);
        chk("subself_nzc", {flag_n, flag_z, flag_c}, 3'b010);

        step(0, 1, ins(1, 3, 0, 8'hA5));
        step(0, 1, ins(10, 3, 0, 8'h00));
        chk("shr_res", result, 8'h52);
        chk("shr_c", flag_c, 1);
        step(0, 1, ins(9, 3, 0, 8'h00));
        chk("shl_res", result, 8'hA4);
        chk("shl_nzc", {flag_n, flag_z, flag_c}, 3'b100);
        step(0, 1, ins(8, 2, 3, 8'h00));
        chk("not_res", result, 8'h5B);
        chk("not_model", m_regs[2], 8'h5B);

        // Idle then a reserved opcode: only the reserved cycle retires.
        for (int k = 0; k < 3; k++) begin
            step(0, 0, ins(3, 0, 1, 8'h00));
            chk("idle_done", done, 0);
        end
        step(0, 1, ins(15, 2, 3, 8'hFF));
        chk("rsv_done", done, 1);
        chk("rsv_res", result, 8'h5B);
        chk("rsv_nzc", {flag_n, flag_z, flag_c}, 3'b000);

        step(1, 1, ins(3, 0, 1, 8'h00));
        chk("midrst_done", done, 0);
        chk("midrst_res", result, 0);
        step(0, 1, ins(1, 0, 0, 8'h12));
        chk("postrst_res", result, 8'h12);
        chk("postrst_done", done, 1);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
                 16'($urandom_range(0, 65535)));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
